// File: rtl/shared_reg_arbiter.sv
`timescale 1ns/1ps
// shared_reg_arbiter
// Round-robin write arbiter in front of one shared resettable register.
// Requesters compete for a single write port. A winner may lock the port for
// a burst of up to MAX_LOCK consecutive writes. When the burst ends it drops
// to lowest priority.
//
// Handshake: req[i] is a valid signal held together with its wdata slice.
// The arbiter takes the data at the edge that grants i. gnt[i] is high during
// the following cycle, and that is the acknowledge. A requester that wants to
// write the same value again must drop req for at least one cycle. Dropping
// req before it is granted withdraws the request with no write.
module shared_reg_arbiter #(
  parameter int N        = 64,
  parameter int NREQ     = 4,
  parameter int MAX_LOCK = 8,
  localparam int OW      = $clog2(NREQ),
  localparam int CW      = $clog2(MAX_LOCK + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   lock,
  input  logic [NREQ*N-1:0] wdata,
  output logic [NREQ-1:0]   gnt,
  output logic [N-1:0]      q,
  output logic              q_valid,
  output logic [OW-1:0]     owner,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GRANT  = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  localparam logic [CW-1:0] MAXC = CW'(MAX_LOCK);

  state_t          state, state_n;
  logic [OW-1:0]   ptr;
  logic [CW-1:0]   cnt, cnt_n;
  logic            do_write;
  logic [OW-1:0]   w_sel;
  logic [NREQ-1:0] owner_oh;
  logic [OW:0]     pick_norm;
  logic [OW:0]     pick_lock;
  logic [N-1:0]    w_data;

  // Search cand from start upward with wraparound. Returns {found, index}.
  function automatic logic [OW:0] rr_pick(input logic [NREQ-1:0] cand,
                                          input logic [OW-1:0]   start);
    logic          found;
    logic [OW-1:0] w;
    int            idx;
    found = 1'b0;
    w     = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(start) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && cand[idx]) begin
        found = 1'b1;
        w     = idx[OW-1:0];
      end
    end
    return {found, w};
  endfunction

  // The pointer moves to the requester after the winner, wrapping at NREQ-1.
  function automatic logic [OW-1:0] next_ptr(input logic [OW-1:0] w);
    if (int'(w) == NREQ - 1) return '0;
    else                     return w + 1'b1;
  endfunction

  assign owner_oh  = {{(NREQ-1){1'b0}}, 1'b1} << owner;
  // In IDLE/GRANT, last cycle's grantee is masked so its held data is not
  // written twice.
  assign pick_norm = rr_pick(req & ~gnt, ptr);
  // When a burst ends, the owner is excluded for one arbitration.
  assign pick_lock = rr_pick(req & ~owner_oh, ptr);
  assign w_data    = wdata[int'(w_sel)*N +: N];
  assign state_dbg = state;

  // Next-state, winner selection and burst counter.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    do_write = 1'b0;
    w_sel    = '0;
    case (state)
      S_LOCKED: begin
        if (req[owner] && (cnt < MAXC)) begin
          do_write = 1'b1;
          w_sel    = owner;
          if (lock[owner]) begin
            state_n = S_LOCKED;
            cnt_n   = cnt + 1'b1;
          end else begin
            state_n = S_GRANT;
            cnt_n   = '0;
          end
        end else if (pick_lock[OW]) begin
          do_write = 1'b1;
          w_sel    = pick_lock[OW-1:0];
          if (lock[pick_lock[OW-1:0]]) begin
            state_n = S_LOCKED;
            cnt_n   = CW'(1);
          end else begin
            state_n = S_GRANT;
            cnt_n   = '0;
          end
        end else begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end
      end
      default: begin
        if (pick_norm[OW]) begin
          do_write = 1'b1;
          w_sel    = pick_norm[OW-1:0];
          if (lock[pick_norm[OW-1:0]]) begin
            state_n = S_LOCKED;
            cnt_n   = CW'(1);
          end else begin
            state_n = S_GRANT;
            cnt_n   = '0;
          end
        end else begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end
      end
    endcase
  end

  // State register and arbitration bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      ptr   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (do_write) ptr <= next_ptr(w_sel);
    end
  end

  // Shared register, grant vector and owner. The register holds its value
  // when no write happens.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q       <= '0;
      q_valid <= 1'b0;
      gnt     <= '0;
      owner   <= '0;
    end else begin
      gnt <= do_write ? ({{(NREQ-1){1'b0}}, 1'b1} << w_sel) : '0;
      if (do_write) begin
        q       <= w_data;
        q_valid <= 1'b1;
        owner   <= w_sel;
      end
    end
  end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
`timescale 1ns/1ps
// Testbench for shared_reg_arbiter (N=64, NREQ=4, MAX_LOCK=8).
// Expected grant/data pairs are queued when stimulus is applied and checked
// one cycle at a time after each rising edge.
module tb_shared_reg_arbiter;

  localparam int N    = 64;
  localparam int NREQ = 4;

  logic              clk;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   lock;
  logic [NREQ*N-1:0] wdata;
  logic [NREQ-1:0]   gnt;
  logic [N-1:0]      q;
  logic              q_valid;
  logic [1:0]        owner;
  logic [1:0]        state_dbg;

  logic [3:0]   exp_gnt_q[$];
  logic [N-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  logic [N-1:0] d [4];

  shared_reg_arbiter #(.N(N), .NREQ(NREQ), .MAX_LOCK(8)) dut (
    .clk(clk), .reset(reset), .req(req), .lock(lock), .wdata(wdata),
    .gnt(gnt), .q(q), .q_valid(q_valid), .owner(owner), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic set_data(input logic [N-1:0] a, b, c, e);
    d[0] = a; d[1] = b; d[2] = c; d[3] = e;
    wdata = {e, c, b, a};
  endtask

  task automatic push_exp(input logic [3:0] g, input logic [N-1:0] v);
    exp_gnt_q.push_back(g);
    exp_q.push_back(v);
  endtask

  // Advance one edge and compare the DUT against the next queued expectation.
  task automatic run_cycle(input string tag);
    logic [3:0]   eg;
    logic [N-1:0] ev;
    @(posedge clk);
    #1;
    if (exp_gnt_q.size() == 0 || exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      eg = exp_gnt_q.pop_front();
      ev = exp_q.pop_front();
      check({tag, "_gnt"}, {60'd0, gnt}, {60'd0, eg});
      check({tag, "_q"}, q, ev);
    end
  endtask

  // Assert reset for two edges with the given request pattern, then release on
  // a falling edge so the next rising edge is the first arbitration.
  task automatic do_reset(input logic [3:0] r, input logic [3:0] l);
    @(negedge clk);
    reset = 1'b0;
    req   = '0;
    lock  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    req   = r;
    lock  = l;
    reset = 1'b1;
  endtask

  // stimulus
  initial begin
    reset = 1'b1;
    req   = '0;
    lock  = '0;
    set_data(64'd119, 64'd5, 64'd39, 64'd102);

    // 1: reset with all requesting, then first grant after release
    @(negedge clk);
    reset = 1'b0;
    req   = 4'b1111;
    #2;
    check("rst_gnt", {60'd0, gnt}, 64'd0);
    check("rst_q", q, 64'd0);
    check("rst_qv", {63'd0, q_valid}, 64'd0);
    check("rst_owner", {62'd0, owner}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    push_exp(4'b0001, 64'd119);
    run_cycle("t1");
    check("t1_qv", {63'd0, q_valid}, 64'd1);

    // 2: full rotation with all requesting, no lock
    do_reset(4'b1111, 4'b0000);
    push_exp(4'b0001, d[0]); push_exp(4'b0010, d[1]);
    push_exp(4'b0100, d[2]); push_exp(4'b1000, d[3]);
    push_exp(4'b0001, d[0]);
    for (int i = 0; i < 5; i++) run_cycle("t2");
    check("t2_owner", {62'd0, owner}, 64'd0);

    // 2b: rotation with random data, two full rounds
    set_data({$urandom, $urandom}, {$urandom, $urandom},
             {$urandom, $urandom}, {$urandom, $urandom});
    do_reset(4'b1111, 4'b0000);
    for (int i = 0; i < 8; i++) push_exp(4'b0001 << (i % 4), d[i % 4]);
    for (int i = 0; i < 8; i++) run_cycle("t2b");
    check("t2b_owner", {62'd0, owner}, 64'd3);

    // 3: single held requester alternates grant/idle because of the mask
    set_data(64'd0, 64'd0, 64'd21, 64'd0);
    do_reset(4'b0100, 4'b0000);
    push_exp(4'b0100, 64'd21); push_exp(4'b0000, 64'd21);
    push_exp(4'b0100, 64'd21); push_exp(4'b0000, 64'd21);
    for (int i = 0; i < 4; i++) run_cycle("t3");
    check("t3_owner", {62'd0, owner}, 64'd2);

    // 4: locked burst capped at 8, then the other requester, then a new burst
    set_data(64'd0, 64'd1111, 64'd0, 64'd3333);
    do_reset(4'b1010, 4'b0010);
    for (int i = 0; i < 8; i++) push_exp(4'b0010, 64'd1111);
    push_exp(4'b1000, 64'd3333);
    push_exp(4'b0010, 64'd1111);
    for (int i = 0; i < 8; i++) run_cycle("t4_burst");
    check("t4_locked", {62'd0, state_dbg}, 64'd2);
    run_cycle("t4_other");
    check("t4_owner", {62'd0, owner}, 64'd3);
    run_cycle("t4_again");

    // 5: lock dropped at the third grant ends the burst early
    set_data(64'd0, 64'd77, 64'd0, 64'd88);
    do_reset(4'b1010, 4'b0010);
    push_exp(4'b0010, 64'd77); push_exp(4'b0010, 64'd77);
    push_exp(4'b0010, 64'd77); push_exp(4'b1000, 64'd88);
    run_cycle("t5");
    run_cycle("t5");
    lock = 4'b0000;
    run_cycle("t5");
    run_cycle("t5");

    // 6: asynchronous reset in the middle of a locked burst
    set_data(64'd500, 64'd600, 64'd700, 64'd800);
    do_reset(4'b1010, 4'b0010);
    for (int i = 0; i < 3; i++) push_exp(4'b0010, 64'd600);
    for (int i = 0; i < 3; i++) run_cycle("t6_burst");
    #2;
    reset = 1'b0;
    #1;
    check("t6_async_gnt", {60'd0, gnt}, 64'd0);
    check("t6_async_q", q, 64'd0);
    check("t6_async_qv", {63'd0, q_valid}, 64'd0);
    @(negedge clk);
    req   = 4'b1111;
    lock  = 4'b0000;
    reset = 1'b1;
    push_exp(4'b0001, 64'd500);
    run_cycle("t6_after");

    check("sb_drained", 64'(exp_gnt_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // global time bound
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
